// File: rtl/scan_sequencer.sv
// Scans the enabled channels of a 3-to-8 decoder in ascending order, holding
// the decoder enable on each visited channel for a programmable dwell time.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StSeek, StDwell, StFin} state_t;

  state_t             state_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;

  // en, busy and done are kept as flops updated alongside every state change,
  // so each one always mirrors the state the FSM is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            sel     <= '0;
            busy    <= 1'b1;
            if (mask != 8'h00) begin
              state_q <= StSeek;
            end else begin
              state_q <= StFin;
              done    <= 1'b1;
            end
          end
        end
        StSeek: begin
          if (mask_q[sel]) begin
            state_q <= StDwell;
            cnt_q   <= dwell_q;
            en      <= 1'b1;
          end else if (sel != 3'd7) begin
            sel <= sel + 3'd1;
          end else begin
            state_q <= StFin;
            done    <= 1'b1;
          end
        end
        StDwell: begin
          if (cnt_q == '0) begin
            en <= 1'b0;
            if (sel == 3'd7) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q <= StSeek;
              sel     <= sel + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        StFin: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          sel     <= '0;
          en      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the dwell-length input.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  scan request; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminate the scan immediately.
REQ-006 Port: mask  input  8  channel-enable bits; bit i=1 means channel i is visited.
REQ-007 Port: dwell  input  DWELL_W  enable-hold length per channel, minus one.
REQ-008 Port: sel  output  3  channel index; drives the 3-to-8 decoder address.
REQ-009 Port: en  output  1  decoder enable; high only while a channel is being driven.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.

Function
REQ-012 The block SHALL be a registered FSM with states IDLE, SEEK, DWELL and FIN; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE with start=1 and abort=0 SHALL:
- latch mask and dwell into internal registers;
- set sel=0;
- go to SEEK if the latched mask is non-zero, else go to FIN.
REQ-014 Changes on mask and dwell after the start cycle SHALL have no effect until the next scan.
REQ-015 SEEK SHALL examine one channel per cycle, with the following transitions:
- latched mask[sel]=1: go to DWELL and load the dwell counter with the latched dwell;
- latched mask[sel]=0 and sel<7: increment sel and stay in SEEK;
- latched mask[sel]=0 and sel=7: go to FIN.
REQ-016 DWELL SHALL hold en=1 with sel stable for exactly dwell+1 consecutive cycles; dwell=0 gives one cycle, and the maximum value gives 2^DWELL_W cycles.
REQ-017 On the last DWELL cycle the FSM SHALL go to FIN if sel=7, else increment sel and go to SEEK.
REQ-018 sel SHALL never wrap from 7 to 0 within a scan.
REQ-019 FIN SHALL assert done=1 for exactly one cycle, with en=0 and busy=1, then return to IDLE.
REQ-020 en SHALL be 1 only in DWELL; done SHALL be 1 only in FIN.
REQ-021 Latency from start to the first en cycle SHALL be 2 cycles when mask[0]=1: start cycle, SEEK, then en high.
REQ-022 An unmasked channel SHALL add exactly one SEEK cycle.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge, with:
- en=0, busy=0 and sel=0 from that edge;
- no done pulse;
- priority over start and over all FSM transitions.
REQ-025 abort and start together in IDLE SHALL leave the block in IDLE.
REQ-026 A scan SHALL visit set mask bits in ascending channel order, each exactly once.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE with sel=0, en=0, busy=0, done=0 and the latched mask, latched dwell and dwell counter all zero.
REQ-028 rst SHALL take priority over abort and start.
REQ-029 Reset mid-scan SHALL abandon the scan with no done pulse.
REQ-030 The first scan after rst deasserts SHALL be accepted on the first cycle with start=1.

Verification
REQ-031 Directed scenario: mask=8'hFF, dwell=0, pulse start -> en high for 1 cycle on each sel 0..7, with one SEEK gap between channels; done pulse 17 cycles after start; busy=1 throughout.
REQ-032 Directed scenario: mask=8'b1000_0100, dwell=3 -> en high 4 cycles at sel=2, then 4 cycles at sel=7; then done; en never high at any other sel.
REQ-033 Directed scenario: mask=8'h00, start -> done=1 on the next cycle, en never high, busy high for that one cycle only.
REQ-034 Directed scenario: mask=8'h01, dwell=15, with DWELL_W=4 -> en high 16 cycles at sel=0; SEEK through channels 1..7 with no en; done at cycle 25 after start.
REQ-035 Directed scenario: abort during the second cycle of DWELL at sel=3 -> next cycle en=0, busy=0, sel=0, no done; a following start runs a full scan normally.
REQ-036 Directed scenario: rst asserted mid-SEEK, and start re-pulsed while busy -> reset values of REQ-027 hold; start while busy does not restart or extend the scan; done count equals the number of started scans.
